// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS control path: opcodes, ALUOP codes,
// sequencer states and the packed control word.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] ALUOP_ADD   = 6'b000000;
  localparam logic [5:0] ALUOP_SUB   = 6'b000001;
  localparam logic [5:0] ALUOP_FUNCT = 6'b000010;

  typedef enum logic [3:0] {
    StIdle    = 4'd0,
    StFetch   = 4'd1,
    StDecode  = 4'd2,
    StMemAdr  = 4'd3,
    StMemRd   = 4'd4,
    StMemWb   = 4'd5,
    StMemWr   = 4'd6,
    StRtypeEx = 4'd7,
    StRtypeWb = 4'd8,
    StBeqEx   = 4'd9,
    StAddiEx  = 4'd10,
    StAddiWb  = 4'd11,
    StJEx     = 4'd12,
    StBneEx   = 4'd13
  } state_t;

  typedef struct packed {
    logic       pc_en;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [5:0] aluop;
    logic [1:0] pc_source;
  } ctrl_t;

endpackage

// File: rtl/mc_ctrl_outputs.sv
// Combinational state -> control-word decode for the multicycle sequencer.
// BNEEX decode is present only when MC_BNE_EN is defined.
module mc_ctrl_outputs
  import mips_pkg::*;
(
  input  state_t state,
  input  logic   zero,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      StFetch: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = 2'b01;
        ctrl.aluop     = ALUOP_ADD;
        // PC and IR only advance once the instruction word has actually arrived.
        ctrl.ir_write  = mem_ready;
        ctrl.pc_en     = mem_ready;
      end
      StDecode: begin
        ctrl.alu_src_b = 2'b11;
        ctrl.aluop     = ALUOP_ADD;
      end
      StMemAdr: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
        ctrl.aluop     = ALUOP_ADD;
      end
      StMemRd: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      StMemWb: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      StMemWr: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      StRtypeEx: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.aluop     = ALUOP_FUNCT;
      end
      StRtypeWb: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      StBeqEx: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.aluop     = ALUOP_SUB;
        ctrl.pc_source = 2'b01;
        ctrl.pc_en     = zero;
      end
`ifdef MC_BNE_EN
      StBneEx: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.aluop     = ALUOP_SUB;
        ctrl.pc_source = 2'b01;
        ctrl.pc_en     = ~zero;
      end
`endif
      StAddiEx: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
        ctrl.aluop     = ALUOP_ADD;
      end
      StAddiWb: begin
        ctrl.reg_write = 1'b1;
      end
      StJEx: begin
        ctrl.pc_source = 2'b10;
        ctrl.pc_en     = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mc_main_control.sv
// Main sequencer of the multicycle MIPS core: state register, next-state logic and
// illegal-opcode flag. Define MC_BNE_EN to add bne support.
module mc_main_control
  import mips_pkg::*;
#(
  parameter int unsigned ALUOP_W = 6,
  parameter int unsigned STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_en,
  output logic               iord,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [ALUOP_W-1:0] ALUOP,
  output logic [1:0]         pc_source,
  output logic               illegal,
  output logic [STATE_W-1:0] state
);

  state_t state_q, state_d;
  ctrl_t  ctrl;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    illegal = 1'b0;
    case (state_q)
      StIdle:  state_d = StFetch;
      StFetch: if (mem_ready) state_d = StDecode;
      StDecode: begin
        case (opcode)
          OP_LW, OP_SW: state_d = StMemAdr;
          OP_RTYPE:     state_d = StRtypeEx;
          OP_BEQ:       state_d = StBeqEx;
          OP_ADDI:      state_d = StAddiEx;
          OP_J:         state_d = StJEx;
`ifdef MC_BNE_EN
          OP_BNE:       state_d = StBneEx;
`endif
          default: begin
            state_d = StFetch;
            illegal = 1'b1;
          end
        endcase
      end
      StMemAdr:  state_d = (opcode == OP_SW) ? StMemWr : StMemRd;
      StMemRd:   if (mem_ready) state_d = StMemWb;
      StMemWb:   state_d = StFetch;
      StMemWr:   if (mem_ready) state_d = StFetch;
      StRtypeEx: state_d = StRtypeWb;
      StRtypeWb: state_d = StFetch;
      StBeqEx:   state_d = StFetch;
`ifdef MC_BNE_EN
      StBneEx:   state_d = StFetch;
`endif
      StAddiEx:  state_d = StAddiWb;
      StAddiWb:  state_d = StFetch;
      StJEx:     state_d = StFetch;
      // Unused encodings behave as IDLE.
      default:   state_d = StFetch;
    endcase
  end

  mc_ctrl_outputs u_outputs (
    .state     (state_q),
    .zero      (zero),
    .mem_ready (mem_ready),
    .ctrl      (ctrl)
  );

  assign pc_en      = ctrl.pc_en;
  assign iord       = ctrl.iord;
  assign mem_read   = ctrl.mem_read;
  assign mem_write  = ctrl.mem_write;
  assign ir_write   = ctrl.ir_write;
  assign reg_dst    = ctrl.reg_dst;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign reg_write  = ctrl.reg_write;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign ALUOP      = ALUOP_W'(ctrl.aluop);
  assign pc_source  = ctrl.pc_source;
  assign state      = STATE_W'(state_q);

endmodule

// File: tb/tb_mc_main_control.sv
// Directed self-checking bench for mc_main_control; inputs change and outputs are
// sampled around the falling edge.
module tb_mc_main_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
  logic       alu_src_a, illegal;
  logic [1:0] alu_src_b, pc_source;
  logic [5:0] ALUOP;
  logic [3:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  // All outputs in one vector, used for the all-zero checks.
  logic [23:0] outs;
  assign outs = {pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
                 alu_src_a, alu_src_b, ALUOP, pc_source, illegal, state};

  always #5 clk = ~clk;

  mc_main_control #(.ALUOP_W(6), .STATE_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_en      (pc_en),
    .iord       (iord),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .ALUOP      (ALUOP),
    .pc_source  (pc_source),
    .illegal    (illegal),
    .state      (state)
  );

  // Leaves the DUT in IDLE just after a falling edge; the next falling edge sees FETCH.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    mem_ready = 1'b1;
    zero = 1'b1;
    #1;
    n_checks++;
    if (outs !== 24'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h want 000000", outs);
    end
    @(negedge clk);
    reset = 1'b0;
    mem_ready = 1'b0;
    zero = 1'b0;
    #1;
    n_checks++;
    if (state !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_idle: state got %0d want 0", state);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if ({state, mem_read, iord, alu_src_a, alu_src_b, ALUOP, pc_source}
        !== {4'd1, 1'b1, 1'b0, 1'b0, 2'b01, 6'b000000, 2'b00}) begin
      n_fail++;
      $display("FAIL reset_to_fetch: state %0d mr %b src_b %b aluop %b want 1 1 01 000000",
               state, mem_read, alu_src_b, ALUOP);
    end
  endtask

  task automatic test_fetch_stall();
    do_reset();
    opcode = 6'b000000;
    mem_ready = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if ({state, mem_read, ir_write, pc_en, ALUOP} !== {4'd1, 1'b1, 1'b0, 1'b0, 6'b000000}) begin
        n_fail++;
        $display("FAIL fetch_stall cycle %0d: st %0d mr %b irw %b pce %b aluop %b want 1 1 0 0 0",
                 i, state, mem_read, ir_write, pc_en, ALUOP);
      end
      @(negedge clk);
    end
    mem_ready = 1'b1;
    #1;
    n_checks++;
    if ({state, ir_write, pc_en, ALUOP} !== {4'd1, 1'b1, 1'b1, 6'b000000}) begin
      n_fail++;
      $display("FAIL fetch_ready: st %0d irw %b pce %b aluop %b want 1 1 1 000000",
               state, ir_write, pc_en, ALUOP);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if ({state, alu_src_b, ir_write, pc_en} !== {4'd2, 2'b11, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL fetch_to_decode: st %0d src_b %b irw %b pce %b want 2 11 0 0",
               state, alu_src_b, ir_write, pc_en);
    end
  endtask

  task automatic test_lw();
    logic [3:0] exp_st [6] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd1};
    do_reset();
    opcode = 6'b100011;
    mem_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      n_checks++;
      if (state !== exp_st[i]) begin
        n_fail++;
        $display("FAIL lw_seq step %0d: state got %0d want %0d", i, state, exp_st[i]);
      end
      if (exp_st[i] == 4'd3) begin
        n_checks++;
        if ({alu_src_a, alu_src_b, ALUOP} !== {1'b1, 2'b10, 6'b000000}) begin
          n_fail++;
          $display("FAIL lw_memadr: a %b b %b aluop %b want 1 10 000000",
                   alu_src_a, alu_src_b, ALUOP);
        end
      end
      if (exp_st[i] == 4'd4) begin
        n_checks++;
        if ({mem_read, mem_write, iord, reg_write} !== 4'b1010) begin
          n_fail++;
          $display("FAIL lw_memrd: mr %b mw %b iord %b rw %b want 1 0 1 0",
                   mem_read, mem_write, iord, reg_write);
        end
      end
      if (exp_st[i] == 4'd5) begin
        n_checks++;
        if ({reg_write, mem_to_reg, reg_dst, pc_en, mem_read} !== 5'b11000) begin
          n_fail++;
          $display("FAIL lw_memwb: rw %b m2r %b rd %b pce %b mr %b want 1 1 0 0 0",
                   reg_write, mem_to_reg, reg_dst, pc_en, mem_read);
        end
      end
    end
  endtask

  task automatic test_sw_stall();
    do_reset();
    opcode = 6'b101011;
    mem_ready = 1'b1;
    repeat (4) @(negedge clk);
    mem_ready = 1'b0;
    #1;
    n_checks++;
    if ({state, mem_write, mem_read, iord} !== {4'd6, 1'b1, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL sw_memwr: st %0d mw %b mr %b iord %b want 6 1 0 1",
               state, mem_write, mem_read, iord);
    end
    @(negedge clk);
    mem_ready = 1'b1;
    #1;
    n_checks++;
    if ({state, mem_write} !== {4'd6, 1'b1}) begin
      n_fail++;
      $display("FAIL sw_hold: st %0d mw %b want 6 1", state, mem_write);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (state !== 4'd1) begin
      n_fail++;
      $display("FAIL sw_done: state got %0d want 1", state);
    end
  endtask

  task automatic test_branch(input logic [5:0] op, input logic z, input logic exp_pce,
                             input logic [3:0] exp_st);
    do_reset();
    opcode = op;
    zero = z;
    mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    mem_ready = 1'b0;
    #1;
    n_checks++;
    if ({state, pc_en, pc_source, ALUOP, alu_src_a, alu_src_b, reg_write}
        !== {exp_st, exp_pce, 2'b01, 6'b000001, 1'b1, 2'b00, 1'b0}) begin
      n_fail++;
      $display("FAIL branch op %b z %b: st %0d pce %b psrc %b aluop %b want %0d %b 01 000001",
               op, z, state, pc_en, pc_source, ALUOP, exp_st, exp_pce);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (state !== 4'd1) begin
      n_fail++;
      $display("FAIL branch_return op %b: state got %0d want 1", op, state);
    end
    zero = 1'b0;
  endtask

  task automatic test_rtype();
    do_reset();
    opcode = 6'b000000;
    mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if ({state, ALUOP, alu_src_a, alu_src_b} !== {4'd7, 6'b000010, 1'b1, 2'b00}) begin
      n_fail++;
      $display("FAIL rtype_ex: st %0d aluop %b a %b b %b want 7 000010 1 00",
               state, ALUOP, alu_src_a, alu_src_b);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if ({state, reg_write, reg_dst, mem_to_reg, pc_en} !== {4'd8, 4'b1100}) begin
      n_fail++;
      $display("FAIL rtype_wb: st %0d rw %b rd %b m2r %b pce %b want 8 1 1 0 0",
               state, reg_write, reg_dst, mem_to_reg, pc_en);
    end
  endtask

  task automatic test_addi();
    do_reset();
    opcode = 6'b001000;
    mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if ({state, ALUOP, alu_src_a, alu_src_b} !== {4'd10, 6'b000000, 1'b1, 2'b10}) begin
      n_fail++;
      $display("FAIL addi_ex: st %0d aluop %b a %b b %b want 10 000000 1 10",
               state, ALUOP, alu_src_a, alu_src_b);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if ({state, reg_write, reg_dst, mem_to_reg} !== {4'd11, 3'b100}) begin
      n_fail++;
      $display("FAIL addi_wb: st %0d rw %b rd %b m2r %b want 11 1 0 0",
               state, reg_write, reg_dst, mem_to_reg);
    end
  endtask

  task automatic test_jump();
    do_reset();
    opcode = 6'b000010;
    mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if ({state, pc_source, pc_en, reg_write} !== {4'd12, 2'b10, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL jump_ex: st %0d psrc %b pce %b rw %b want 12 10 1 0",
               state, pc_source, pc_en, reg_write);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (state !== 4'd1) begin
      n_fail++;
      $display("FAIL jump_return: state got %0d want 1", state);
    end
  endtask

  task automatic test_illegal(input logic [5:0] op);
    do_reset();
    opcode = op;
    mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if ({state, illegal} !== {4'd2, 1'b1}) begin
      n_fail++;
      $display("FAIL illegal_pulse op %b: st %0d ill %b want 2 1", op, state, illegal);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if ({state, illegal} !== {4'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL illegal_return op %b: st %0d ill %b want 1 0", op, state, illegal);
    end
  endtask

  task automatic test_reset_mid_memrd();
    do_reset();
    opcode = 6'b100011;
    mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    mem_ready = 1'b0;
    @(negedge clk);
    #1;
    n_checks++;
    if ({state, mem_read} !== {4'd4, 1'b1}) begin
      n_fail++;
      $display("FAIL midrd_stall: st %0d mr %b want 4 1", state, mem_read);
    end
    #1;
    reset = 1'b1;
    #1;
    n_checks++;
    if (outs !== 24'd0) begin
      n_fail++;
      $display("FAIL midrd_async_reset: got %h want 000000", outs);
    end
    @(negedge clk);
    mem_ready = 1'b1;
    #1;
    n_checks++;
    if (outs !== 24'd0) begin
      n_fail++;
      $display("FAIL midrd_reset_hold: got %h want 000000", outs);
    end
    reset = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    n_checks++;
    if ({state, mem_read, reg_write} !== {4'd1, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL midrd_refetch: st %0d mr %b rw %b want 1 1 0", state, mem_read, reg_write);
    end
  endtask

  initial begin
    reset = 1'b1;
    opcode = 6'd0;
    zero = 1'b0;
    mem_ready = 1'b0;
    test_reset();
    test_fetch_stall();
    test_lw();
    test_sw_stall();
    test_branch(6'b000100, 1'b1, 1'b1, 4'd9);
    test_branch(6'b000100, 1'b0, 1'b0, 4'd9);
    test_rtype();
    test_addi();
    test_jump();
    test_illegal(6'b111111);
`ifdef MC_BNE_EN
    test_branch(6'b000101, 1'b0, 1'b1, 4'd13);
    test_branch(6'b000101, 1'b1, 1'b0, 4'd13);
`else
    test_illegal(6'b000101);
`endif
    test_reset_mid_memrd();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
